// File: rtl/calc_pkg.sv
// Shared definitions for the accumulator calculator sequencer: function select
// codes, shared-ALU control codes and the sequencer state encoding.
package calc_pkg;

    typedef logic [2:0] func_t;

    localparam func_t FUNC_ADD = 3'b000;
    localparam func_t FUNC_SUB = 3'b001;
    localparam func_t FUNC_AND = 3'b010;
    localparam func_t FUNC_OR  = 3'b011;
    localparam func_t FUNC_XOR = 3'b100;
    localparam func_t FUNC_LT  = 3'b101;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_LT  = 4'b0111;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        EXEC         = 2'd1,
        DONE         = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    // Unused select codes (110/111) fall back to ADD.
    function automatic logic [3:0] func_to_alu_op(input func_t f);
        logic [3:0] op;
        case (f)
            FUNC_SUB: op = ALU_SUB;
            FUNC_AND: op = ALU_AND;
            FUNC_OR:  op = ALU_OR;
            FUNC_XOR: op = ALU_XOR;
            FUNC_LT:  op = ALU_LT;
            default:  op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stability counter for a raw bouncing button.
// The debounced level flips only after DEBOUNCE_CYCLES consecutive mismatches.
module btn_debounce #(
    parameter int   DEBOUNCE_CYCLES = 650000,
    parameter logic RESET_LEVEL     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= RESET_LEVEL;
            count <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != level) begin
                // The edge that sees the final mismatch flips the level.
                if (count == CNT_LAST) begin
                    level <= ~level;
                    count <= '0;
                end else begin
                    count <= count + CW'(1);
                end
            end else begin
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Sequences the shared ALU: one operation per debounced execute press, result
// written back to the accumulator when leaving EXEC.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 650000,
    parameter logic [31:0] ACC_RESET       = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btnc,
    input  logic [2:0]  func,
    input  logic [15:0] sw,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    output logic [31:0] acc,
    output logic [15:0] led,
    output logic        busy,
    output logic        done,
    output logic [15:0] op_count,
    output state_t      dbg_state
);

    state_t state;
    state_t state_next;
    logic   level;
    logic   latch_en;
    logic   write_en;

    // The debounced level starts high so a button held through reset must be
    // released before it can trigger an operation.
    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_LEVEL     (1'b1)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .raw   (btnc),
        .level (level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_RELEASE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        latch_en   = 1'b0;
        write_en   = 1'b0;
        case (state)
            IDLE: begin
                if (level) begin
                    state_next = EXEC;
                    latch_en   = 1'b1;
                end
            end
            EXEC: begin
                state_next = DONE;
                write_en   = 1'b1;
            end
            DONE:         state_next = WAIT_RELEASE;
            WAIT_RELEASE: begin
                if (!level) begin
                    state_next = IDLE;
                end
            end
            default:      state_next = IDLE;
        endcase
    end

    // Operands are captured once on entry to EXEC; later func/sw changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op   <= ALU_ADD;
            alu_b    <= 32'd0;
            acc      <= ACC_RESET;
            op_count <= 16'd0;
        end else begin
            if (latch_en) begin
                alu_op <= func_to_alu_op(func);
                alu_b  <= {16'b0, sw};
            end
            if (write_en) begin
                acc      <= alu_result;
                op_count <= op_count + 16'd1;
            end
        end
    end

    // done is a single-cycle completion strobe with no ready: acc and op_count
    // already hold the new result in the cycle done is high, busy spans EXEC..DONE.
    assign alu_a     = acc;
    assign led       = acc[15:0];
    assign busy      = (state == EXEC) || (state == DONE);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_calc_sequencer.sv
// Randomized scoreboard bench for calc_sequencer with a behavioural ALU and
// an accumulator model driven by the calculator's arithmetic rules.
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        btnc;
  logic [2:0]  func;
  logic [15:0] sw;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic [31:0] acc;
  logic [15:0] led;
  logic        busy;
  logic        done;
  logic [15:0] op_count;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] acc_m;
  logic [15:0] cnt_m;
  logic [31:0] exp_q[$];
  logic [15:0] exp_cnt_q[$];
  logic [35:0] exp_exec_q[$];

  calc_sequencer #(
    .DEBOUNCE_CYCLES (D),
    .ACC_RESET       (32'd0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btnc       (btnc),
    .func       (func),
    .sw         (sw),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .acc        (acc),
    .led        (led),
    .busy       (busy),
    .done       (done),
    .op_count   (op_count),
    .dbg_state  (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // shared ALU stand-in, decoded from the board ALU control codes
  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      4'b1101: alu_result = alu_a ^ alu_b;
      default: alu_result = 32'd0;
    endcase
  end

  // reference model: what the calculator should do to the accumulator
  function automatic logic [31:0] model_op(input logic [2:0] f, input logic [31:0] a,
                                           input logic [15:0] s);
    logic [31:0] b;
    int signed sa;
    int signed sb;
    b  = {16'b0, s};
    sa = a;
    sb = b;
    case (f)
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
      default: return a + b;
    endcase
  endfunction

  function automatic logic [3:0] model_code(input logic [2:0] f);
    case (f)
      3'd1:    return 4'b0110;
      3'd2:    return 4'b0000;
      3'd3:    return 4'b0001;
      3'd4:    return 4'b1101;
      3'd5:    return 4'b0111;
      default: return 4'b0010;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input int qsize);
    checks++;
    errors++;
    $display("FAIL %s: event seen with %0d queued expectations", name, qsize);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && !done) begin
        if (exp_exec_q.size() == 0) begin
          flag("unexpected_exec", 0);
        end else begin
          logic [35:0] e;
          e = exp_exec_q.pop_front();
          check("exec_alu_op", 32'(alu_op), 32'(e[35:32]));
          check("exec_alu_b", alu_b, e[31:0]);
        end
      end
      if (done) begin
        check("done_busy", 32'(busy), 32'd1);
        if (exp_q.size() == 0) begin
          flag("unexpected_done", 0);
        end else begin
          logic [31:0] ea;
          logic [15:0] ec;
          ea = exp_q.pop_front();
          ec = exp_cnt_q.pop_front();
          check("done_acc", acc, ea);
          check("done_op_count", 32'(op_count), 32'(ec));
          check("done_led", 32'(led), 32'(ea[15:0]));
        end
      end
    end
  end

  // driver tasks
  task automatic clear_model();
    acc_m = 32'd0;
    cnt_m = 16'd0;
    exp_q.delete();
    exp_cnt_q.delete();
    exp_exec_q.delete();
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    btnc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_model();
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [2:0] f, input logic [15:0] s, input int hold, input bit lat);
    logic [31:0] prev;
    logic [31:0] nxt;
    prev  = acc_m;
    nxt   = model_op(f, acc_m, s);
    acc_m = nxt;
    cnt_m = cnt_m + 16'd1;
    exp_q.push_back(nxt);
    exp_cnt_q.push_back(cnt_m);
    exp_exec_q.push_back({model_code(f), 16'b0, s});
    func = f;
    sw   = s;
    btnc = 1'b1;
    for (int i = 0; i < hold + 14; i++) begin
      @(posedge clk);
      #1;
      if (i == hold - 1) btnc = 1'b0;
      if (i == 8) begin
        func = 3'($urandom_range(0, 7));
        sw   = 16'($urandom);
      end
      if (lat && i == 6) check("latency_acc_before", acc, prev);
      if (lat && i == 7) begin
        check("latency_acc_after", acc, nxt);
        check("latency_done", 32'(done), 32'd1);
      end
    end
  endtask

  task automatic glitch(input int len);
    btnc = 1'b1;
    for (int i = 0; i < len + 14; i++) begin
      @(posedge clk);
      #1;
      if (i == len - 1) btnc = 1'b0;
      check("glitch_busy", 32'(busy), 32'd0);
    end
    check("glitch_acc", acc, acc_m);
  endtask

  initial begin
    rst  = 1'b1;
    btnc = 1'b1;
    func = 3'd0;
    sw   = 16'd0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check("rst_acc", acc, 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'h2);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(WAIT_RELEASE));

    // button held through reset must not fire
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    btnc = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("held_acc", acc, 32'd0);
    check("held_op_count", 32'(op_count), 32'd0);
    check("held_state", 32'(dbg_state), 32'(IDLE));

    press(3'b000, 16'h0005, 6, 1'b1);
    check("add5_acc", acc, 32'd5);
    check("add5_op_count", 32'(op_count), 32'd1);
    press(3'b001, 16'h0007, 6, 1'b0);
    check("sub7_acc", acc, 32'hFFFF_FFFE);
    press(3'b101, 16'h0001, 6, 1'b0);
    check("lt_acc", acc, 32'd1);

    glitch(D - 1);
    press(3'b000, 16'h0010, D, 1'b0);
    check("min_press_acc", acc, 32'h11);
    press(3'b100, 16'h00F0, 50, 1'b0);
    check("long_hold_op_count", 32'(op_count), 32'(cnt_m));

    for (int n = 0; n < 24; n++) begin
      press(3'($urandom_range(0, 7)), 16'($urandom), $urandom_range(D, 30), 1'b0);
    end
    check("random_acc", acc, acc_m);

    do_reset();
    press(3'b001, 16'h0001, 6, 1'b0);
    check("wrap_sub_acc", acc, 32'hFFFF_FFFF);
    press(3'b000, 16'h0001, 6, 1'b0);
    check("wrap_add_acc", acc, 32'd0);

    // reset asserted while the operation is in EXEC
    exp_exec_q.push_back({4'b0010, 16'b0, 16'h0003});
    func = 3'b000;
    sw   = 16'h0003;
    btnc = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
        @(negedge clk);
        if (busy && !done) seen = 1'b1;
      end
      check("rst_exec_reached", 32'(seen), 32'd1);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear_model();
    rst = 1'b0;
    #1;
    check("rst_exec_acc", acc, 32'd0);
    check("rst_exec_op_count", 32'(op_count), 32'd0);
    check("rst_exec_state", 32'(dbg_state), 32'(WAIT_RELEASE));
    repeat (10) @(posedge clk);
    #1;
    check("rst_exec_still_waiting", 32'(dbg_state), 32'(WAIT_RELEASE));
    btnc = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("rst_exec_idle", 32'(dbg_state), 32'(IDLE));
    check("rst_exec_no_op", 32'(op_count), 32'd0);
    press(3'b000, 16'h0009, 6, 1'b0);
    check("post_rst_acc", acc, 32'd9);
    check("post_rst_op_count", 32'(op_count), 32'd1);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain_exp_q", 32'(exp_q.size()), 32'd0);
    check("drain_exec_q", 32'(exp_exec_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
